// File: rtl/tx_symbol_scheduler_pkg.sv
// Shared types, 4-ASK level constants and the Gray symbol mapper.
// Used by the scheduler RTL and by TX/RCV benches as a golden mapper.
// Levels are 1s17 (full scale 131072); all fit without saturation.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_DATA  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic signed [17:0] LVL_P3 = 18'sd98304;
  localparam logic signed [17:0] LVL_P1 = 18'sd32768;
  localparam logic signed [17:0] LVL_M1 = -18'sd32768;
  localparam logic signed [17:0] LVL_M3 = -18'sd98304;

  // Gray mapping: adjacent levels differ in one bit.
  function automatic logic signed [17:0] ask4_map(input logic [1:0] s);
    case (s)
      2'b00:   return LVL_M3;
      2'b01:   return LVL_M1;
      2'b11:   return LVL_P1;
      default: return LVL_P3;
    endcase
  endfunction

endpackage

// File: rtl/tx_symbol_scheduler_if.sv
// Symbol stream handshake between an upstream source and the scheduler.
// Transfer happens on a rising edge where sym_valid & sym_ready.
// sym_last marks the final symbol of a frame.
interface tx_symbol_scheduler_if;
  logic [1:0] sym_in;
  logic       sym_valid;
  logic       sym_last;
  logic       sym_ready;

  modport master (output sym_in, output sym_valid, output sym_last, input sym_ready);
  modport slave  (input sym_in, input sym_valid, input sym_last, output sym_ready);
endinterface

// File: rtl/tx_symbol_scheduler.sv
// Framed, zero-stuffed 4-ASK impulse train (preamble, data, zero flush) for TX_filt.
// Latency: start or accepted symbol -> its impulse on x_out one cycle later.
// Backpressure: sym_ready only in fetch cycles; a missed fetch emits an empty slot and sets underrun.
module tx_symbol_scheduler
  import tx_sched_pkg::*;
#(
  parameter int SPS       = 4,
  parameter int PRE_LEN   = 8,
  parameter int FLUSH_LEN = 21
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  tx_symbol_scheduler_if.slave sif,
  output logic signed [17:0]  x_out,
  output logic                busy,
  output logic                done,
  output logic                underrun
);

  localparam int              FW       = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [3:0]      PH_LAST  = 4'(SPS - 1);
  localparam logic [5:0]      PRE_LAST = 6'(PRE_LEN - 1);
  localparam logic [FW-1:0]   FL_LAST  = FW'(FLUSH_LEN - 1);

  state_t             state, state_n;
  logic [3:0]         phase, phase_n;
  logic [5:0]         sym_cnt, sym_cnt_n;
  logic [FW-1:0]      flush_cnt, flush_cnt_n;
  logic               last_flag, last_flag_n;
  logic               underrun_n, done_n;
  logic signed [17:0] x_n;
  logic               fetch, xfer;

  // A fetch closes the last preamble slot or any data slot not already marked last.
  assign fetch = (phase == PH_LAST) &&
                 (((state == ST_PRE) && (sym_cnt == PRE_LAST)) ||
                  ((state == ST_DATA) && !last_flag));
  assign sif.sym_ready = fetch;
  assign xfer          = fetch & sif.sym_valid;
  assign busy          = (state != ST_IDLE);

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      phase     <= '0;
      sym_cnt   <= '0;
      flush_cnt <= '0;
      last_flag <= 1'b0;
      underrun  <= 1'b0;
      done      <= 1'b0;
      x_out     <= '0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      sym_cnt   <= sym_cnt_n;
      flush_cnt <= flush_cnt_n;
      last_flag <= last_flag_n;
      underrun  <= underrun_n;
      done      <= done_n;
      x_out     <= x_n;
    end
  end

  // Next state plus the sample x_out will carry in the next cycle.
  always_comb begin
    state_n     = state;
    phase_n     = phase;
    sym_cnt_n   = sym_cnt;
    flush_cnt_n = flush_cnt;
    last_flag_n = last_flag;
    underrun_n  = underrun;
    done_n      = 1'b0;
    x_n         = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n     = ST_PRE;
          phase_n     = '0;
          sym_cnt_n   = '0;
          last_flag_n = 1'b0;
          underrun_n  = 1'b0;
          x_n         = LVL_P3;
        end
      end
      ST_PRE, ST_DATA: begin
        if (phase != PH_LAST) begin
          phase_n = phase + 4'd1;
        end else begin
          phase_n = '0;
          if (fetch) begin
            state_n = ST_DATA;
            if (xfer) begin
              x_n         = ask4_map(sif.sym_in);
              last_flag_n = sif.sym_last;
            end else begin
              // Empty slot: the same symbol is fetched again at the end of it.
              underrun_n = 1'b1;
            end
          end else if (state == ST_PRE) begin
            sym_cnt_n = sym_cnt + 6'd1;
            // Next preamble index has the opposite parity of the current one.
            x_n       = sym_cnt[0] ? LVL_P3 : LVL_M3;
          end else begin
            state_n     = ST_FLUSH;
            flush_cnt_n = '0;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == FL_LAST) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          flush_cnt_n = flush_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Bench for tx_symbol_scheduler: table-driven frames with a sample scoreboard.
// Expected samples are queued when stimulus is driven and popped per output cycle.
// Covers reset, basic frame, underrun, start-while-busy and async reset mid-frame.
module tb_tx_symbol_scheduler;
  localparam int SPS       = 4;
  localparam int PRE_LEN   = 8;
  localparam int FLUSH_LEN = 21;

  typedef struct {
    logic [1:0] sym;
    int         level;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic signed [17:0] x_out;
  logic               busy, done, underrun;

  tx_symbol_scheduler_if sif();

  tx_symbol_scheduler #(.SPS(SPS), .PRE_LEN(PRE_LEN), .FLUSH_LEN(FLUSH_LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .sif(sif),
    .x_out(x_out), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  vec_t vecs[8];
  int   exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input int t, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0d, want %0d", nm, t, act, exp);
  endtask

  task automatic push_slot(input int lvl);
    exp_q.push_back(lvl);
    for (int i = 0; i < SPS - 1; i++) exp_q.push_back(0);
  endtask

  // One frame of n symbols from vecs[base..]; drop_slot = fetch slot with sym_valid low
  // (-1 none); start_at = cycle index for a stray start pulse (-1 none).
  task automatic run_frame(input int base, input int n, input int drop_slot,
                           input int start_at, input int exp_busy);
    int consumed = 0;
    int slot     = 0;
    int t        = 0;
    int busy_cnt = 0;
    int e;
    bit rdy_e;
    exp_q.delete();
    @(posedge clk); #1;
    start         = 1'b1;
    sif.sym_valid = 1'b1;
    sif.sym_in    = vecs[base].sym;
    sif.sym_last  = 1'b0;
    for (int i = 0; i < PRE_LEN; i++) push_slot((i % 2 == 0) ? 98304 : -98304);
    @(posedge clk); #1;
    while (t < 1000 && exp_q.size() != 0) begin
      start         = (t == start_at);
      rdy_e         = 1'b0;
      sif.sym_valid = 1'b1;
      sif.sym_in    = (consumed < n) ? vecs[base + consumed].sym : 2'b00;
      sif.sym_last  = (consumed == n - 1);
      if (consumed < n && t == (PRE_LEN + slot) * SPS - 1) begin
        rdy_e = 1'b1;
        if (slot == drop_slot) begin
          sif.sym_valid = 1'b0;
          push_slot(0);
        end else begin
          push_slot(vecs[base + consumed].level);
          consumed++;
          if (consumed == n) for (int i = 0; i < FLUSH_LEN; i++) exp_q.push_back(0);
        end
        slot++;
      end
      @(negedge clk);
      e = exp_q.pop_front();
      chk("x_out", t, $signed(x_out), e);
      chk("busy", t, busy, 1);
      chk("sym_ready", t, sif.sym_ready, rdy_e);
      if (t == 0) chk("underrun_clr", t, underrun, 0);
      busy_cnt++;
      @(posedge clk); #1;
      t++;
    end
    start         = 1'b0;
    sif.sym_valid = 1'b0;
    sif.sym_last  = 1'b0;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL frame_timeout: %0d samples outstanding, want 0", exp_q.size());
    end
    @(negedge clk);
    chk("busy_len", t, busy_cnt, exp_busy);
    chk("busy_end", t, busy, 0);
    chk("done", t, done, 1);
    chk("x_idle", t, $signed(x_out), 0);
    chk("underrun_end", t, underrun, (drop_slot >= 0) ? 1 : 0);
    @(negedge clk);
    chk("done_pulse", t + 1, done, 0);
  endtask

  // Start a frame (symbol 00 always offered), assert reset between edges in cycle t_rst.
  task automatic reset_at(input int t_rst, input int x_exp, input int rdy_exp);
    @(posedge clk); #1;
    start         = 1'b1;
    sif.sym_valid = 1'b1;
    sif.sym_in    = vecs[0].sym;
    sif.sym_last  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (t_rst) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_x", t_rst, $signed(x_out), x_exp);
    chk("pre_rst_rdy", t_rst, sif.sym_ready, rdy_exp);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_x", t_rst, $signed(x_out), 0);
    chk("async_rst_busy", t_rst, busy, 0);
    chk("async_rst_rdy", t_rst, sif.sym_ready, 0);
    sif.sym_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{sym: 2'b00, level: -98304};
    vecs[1] = '{sym: 2'b01, level: -32768};
    vecs[2] = '{sym: 2'b11, level:  32768};
    vecs[3] = '{sym: 2'b10, level:  98304};
    vecs[4] = '{sym: 2'b11, level:  32768};
    vecs[5] = '{sym: 2'b00, level: -98304};
    vecs[6] = '{sym: 2'b10, level:  98304};
    vecs[7] = '{sym: 2'b01, level: -32768};

    reset         = 1'b0;
    start         = 1'b0;
    sif.sym_valid = 1'b0;
    sif.sym_in    = 2'b00;
    sif.sym_last  = 1'b0;

    // Held in reset: clock and start must not wake the block.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start         = 1'b1;
      sif.sym_valid = 1'b1;
      @(negedge clk);
      chk("rst_x", i, $signed(x_out), 0);
      chk("rst_busy", i, busy, 0);
      chk("rst_rdy", i, sif.sym_ready, 0);
      chk("rst_done", i, done, 0);
      chk("rst_underrun", i, underrun, 0);
    end
    start         = 1'b0;
    sif.sym_valid = 1'b0;
    #2 reset = 1'b1;

    run_frame(0, 4, -1, -1, 69);   // basic frame 00,01,11,10
    run_frame(4, 4,  2, -1, 73);   // fetch of data symbol 2 starved
    run_frame(0, 4, -1, 40, 69);   // stray start during DATA
    reset_at(35, 0, 1);            // reset in a fetch cycle
    reset_at(32, -98304, 0);       // reset while an impulse is on x_out
    run_frame(4, 4, -1, -1, 69);   // clean frame after reset

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
